// File: rtl/cv32e40x_pkg.sv
// Shared types for the memory protection stage and its PMA lookup.
//   mpu_status_e : response status returned to the requester
//   mpu_state_e  : protection FSM states
//   a_ext_e      : atomic extension configuration
//   pma_cfg_t    : one PMA region (word-address bounds plus attributes)
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    MPU_OK       = 2'b00,
    MPU_RE_FAULT = 2'b01,
    MPU_WR_FAULT = 2'b10
  } mpu_status_e;

  typedef enum logic [1:0] {
    MPU_IDLE   = 2'b00,
    MPU_RE_ERR = 2'b01,
    MPU_WR_ERR = 2'b10
  } mpu_state_e;

  typedef enum logic [1:0] {
    A_NONE   = 2'b00,
    A_ZALRSC = 2'b01,
    A        = 2'b10
  } a_ext_e;

  // A region matches word_addr_low <= addr[31:2] < word_addr_high.
  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
  } pma_cfg_t;

  // Attributes of an address that no configured region covers: I/O.
  localparam pma_cfg_t PMA_R_DEFAULT = '{
    word_addr_low:  32'h0,
    word_addr_high: 32'h0,
    main:           1'b0,
    bufferable:     1'b0,
    cacheable:      1'b0
  };

  // With no regions configured the whole map is plain main memory.
  localparam pma_cfg_t PMA_R_ALL_MAIN = '{
    word_addr_low:  32'h0,
    word_addr_high: 32'hFFFF_FFFF,
    main:           1'b1,
    bufferable:     1'b0,
    cacheable:      1'b0
  };

endpackage

// File: rtl/cv32e40x_pma.sv
// PMA attribute lookup (purely combinational).
//   trans_addr_i     : byte address of the access
//   instr_fetch_i    : access is an instruction fetch
//   load_i           : access is a read
//   atomic_i, misaligned_i, modified_i, pushpop_i, debug_region_i : access qualifiers
//   pma_err_o        : access is not permitted by the attributes
//   bufferable_o     : bufferable tag (stores only)
//   cacheable_o      : cacheable tag
module cv32e40x_pma
  import cv32e40x_pkg::*;
#(
  parameter a_ext_e   A_EXT           = A_NONE,
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT}
) (
  input  logic [31:0] trans_addr_i,
  input  logic        instr_fetch_i,
  input  logic        load_i,
  input  logic        atomic_i,
  input  logic        misaligned_i,
  input  logic        modified_i,
  input  logic        pushpop_i,
  input  logic        debug_region_i,
  output logic        pma_err_o,
  output logic        bufferable_o,
  output logic        cacheable_o
);

  logic [31:0] w_word_addr;
  pma_cfg_t    w_attr;

  assign w_word_addr = {2'b00, trans_addr_i[31:2]};

  always_comb begin
    w_attr = (PMA_NUM_REGIONS == 0) ? PMA_R_ALL_MAIN : PMA_R_DEFAULT;
    // Walk from the top so the lowest-numbered matching region wins.
    for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
      if ((w_word_addr >= PMA_CFG[i].word_addr_low) &&
          (w_word_addr <  PMA_CFG[i].word_addr_high)) begin
        w_attr = PMA_CFG[i];
      end
    end
    // The debug module region behaves as uncached main memory.
    if (debug_region_i) begin
      w_attr            = PMA_R_DEFAULT;
      w_attr.main       = 1'b1;
    end
  end

  // Fetches, atomics and split/compound accesses need main memory;
  // atomics are refused entirely when the core has no A extension.
  assign pma_err_o = (instr_fetch_i && !w_attr.main) ||
                     (atomic_i && ((A_EXT == A_NONE) || !w_attr.main)) ||
                     (!w_attr.main && (misaligned_i || modified_i || pushpop_i));

  assign bufferable_o = w_attr.bufferable && !load_i;
  assign cacheable_o  = w_attr.cacheable;

endmodule

// File: rtl/cv32e40x_mpu.sv
// Memory protection stage between a requester and the OBI bus interface.
// Permitted transactions pass straight through with PMA tags; faulting ones
// are accepted and swallowed, and once every outstanding bus response has
// returned a single fault response is injected.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   core_trans_*                  : requester transaction (valid/ready)
//   bus_trans_*                   : forwarded transaction (valid/ready) + tags
//   bus_resp_valid_i/err_i        : bus response, one per accepted transaction
//   core_resp_valid_o/err_o/status_o : response to requester
// Handshake: a transaction transfers in any cycle where valid and ready are
// both high; valid never depends on ready. Responses have no back-pressure.
module cv32e40x_mpu
  import cv32e40x_pkg::*;
#(
  parameter bit       IF_STAGE        = 1'b0,
  parameter a_ext_e   A_EXT           = A_NONE,
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
  parameter int       MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic        core_trans_atomic_i,
  input  logic        core_trans_misaligned_i,
  input  logic        core_trans_modified_i,
  input  logic        core_trans_pushpop_i,
  input  logic        core_trans_debug_region_i,
  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic        bus_trans_bufferable_o,
  output logic        bus_trans_cacheable_o,
  input  logic        bus_resp_valid_i,
  input  logic        bus_resp_err_i,
  output logic        core_resp_valid_o,
  output logic        core_resp_err_o,
  output mpu_status_e core_resp_status_o
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  mpu_state_e       r_state;
  mpu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_we;
  logic             w_pma_err;
  logic             w_below_max;
  logic             w_bus_hs;

  // The fetch side never writes.
  assign w_we        = IF_STAGE ? 1'b0 : core_trans_we_i;
  assign w_below_max = (r_cnt < MAX_CNT);
  assign w_bus_hs    = bus_trans_valid_o && bus_trans_ready_i;

  cv32e40x_pma #(
    .A_EXT           (A_EXT),
    .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
    .PMA_CFG         (PMA_CFG)
  ) u_pma (
    .trans_addr_i   (core_trans_addr_i),
    .instr_fetch_i  (IF_STAGE),
    .load_i         (!w_we),
    .atomic_i       (core_trans_atomic_i),
    .misaligned_i   (core_trans_misaligned_i),
    .modified_i     (core_trans_modified_i),
    .pushpop_i      (core_trans_pushpop_i),
    .debug_region_i (core_trans_debug_region_i),
    .pma_err_o      (w_pma_err),
    .bufferable_o   (bus_trans_bufferable_o),
    .cacheable_o    (bus_trans_cacheable_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MPU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus_trans_valid_o  = 1'b0;
    core_trans_ready_o = 1'b0;
    core_resp_valid_o  = bus_resp_valid_i;
    core_resp_err_o    = bus_resp_err_i;
    core_resp_status_o = MPU_OK;
    case (r_state)
      MPU_IDLE: begin
        if (core_trans_valid_i && w_pma_err) begin
          // Swallowed: accepted regardless of the outstanding ceiling.
          core_trans_ready_o = 1'b1;
          w_state_nxt        = w_we ? MPU_WR_ERR : MPU_RE_ERR;
        end else begin
          bus_trans_valid_o  = core_trans_valid_i && w_below_max;
          core_trans_ready_o = bus_trans_ready_i && w_below_max;
        end
      end
      MPU_RE_ERR, MPU_WR_ERR: begin
        // Fault goes out only after the bus has fully drained, so it can
        // never collide with a passthrough response.
        if (r_cnt == '0) begin
          core_resp_valid_o  = 1'b1;
          core_resp_err_o    = 1'b0;
          core_resp_status_o = (r_state == MPU_WR_ERR) ? MPU_WR_FAULT : MPU_RE_FAULT;
          w_state_nxt        = MPU_IDLE;
        end
      end
      default: w_state_nxt = MPU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_bus_hs && !bus_resp_valid_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_bus_hs && bus_resp_valid_i) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  a_no_resp_without_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus_resp_valid_i && (r_cnt == '0))
  );

endmodule
